// File: rtl/instr_fetch_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package instr_fetch_pkg;
    localparam int          INSTR_W      = 32;
    localparam logic [31:0] NOP          = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_HOLD   = 2'd3
    } pc_sel_e;

    // Redirect targets are byte addresses; fetch is always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/instr_fetch_hold_buf.sv
// Stall skid buffer: freezes the presented instruction while the pipe is stalled.
module if_hold_buf
    import instr_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               stall,
    input  logic [INSTR_W-1:0] cur_ir,
    input  logic [31:0]        cur_pc_plus4,
    input  logic               cur_valid,
    output logic [INSTR_W-1:0] hold_ir,
    output logic [31:0]        hold_pc,
    output logic               hold_valid
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_ir    <= NOP;
            hold_pc    <= '0;
            hold_valid <= 1'b0;
        end else if (flush) begin
            hold_valid <= 1'b0;
        end else if (stall && !hold_valid) begin
            // A bubble captured here stays a bubble; the pc has not moved, so nothing is lost.
            hold_ir    <= cur_ir;
            hold_pc    <= cur_pc_plus4;
            hold_valid <= cur_valid;
        end else if (!stall) begin
            hold_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: pc sequencing, redirects and 1-cycle synchronous imem response tagging.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    input  logic [31:0]        jump_target,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic [31:0]        pc_plus4,
    output logic               valid
);
    logic [31:0]        pc;
    logic [31:0]        resp_pc;
    logic               resp_valid;
    logic [INSTR_W-1:0] hold_ir;
    logic [31:0]        hold_pc;
    logic               hold_valid;
    logic               redirect;
    pc_sel_e            pc_sel;

    assign redirect  = branch_taken | jump;
    assign imem_addr = pc;

    always_comb begin
        pc_sel = SEL_SEQ;
        if (branch_taken)  pc_sel = SEL_BRANCH;
        else if (jump)     pc_sel = SEL_JUMP;
        else if (stall)    pc_sel = SEL_HOLD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            resp_pc    <= '0;
            resp_valid <= 1'b0;
        end else begin
            case (pc_sel)
                SEL_BRANCH: begin
                    pc         <= word_align(branch_target);
                    resp_valid <= 1'b0;
                end
                SEL_JUMP: begin
                    pc         <= word_align(jump_target);
                    resp_valid <= 1'b0;
                end
                // Memory re-reads pc while stalled; the hold buffer masks that word.
                SEL_HOLD: ;
                default: begin
                    pc         <= pc + 32'd4;
                    resp_pc    <= pc;
                    resp_valid <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        ir       = NOP;
        pc_plus4 = '0;
        if (hold_valid) begin
            ir       = hold_ir;
            pc_plus4 = hold_pc;
        end else if (resp_valid) begin
            ir       = imem_rdata;
            pc_plus4 = resp_pc + 32'd4;
        end
    end

    assign valid = hold_valid | resp_valid;

    if_hold_buf u_hold (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (redirect),
        .stall        (stall),
        .cur_ir       (ir),
        .cur_pc_plus4 (pc_plus4),
        .cur_valid    (valid),
        .hold_ir      (hold_ir),
        .hold_pc      (hold_pc),
        .hold_valid   (hold_valid)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random traffic vs a stream model.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
    logic [31:0] branch_target = '0, jump_target = '0;
    logic [31:0] imem_addr0, imem_rdata0, ir0, pc_plus4_0;
    logic [31:0] imem_addr1, imem_rdata1, ir1, pc_plus4_1;
    logic        valid0, valid1;
    int          checks = 0;
    int          errors = 0;

    // Model: which word is on ir, and which address is fetched next.
    logic        m_valid [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_next  [2];
    logic [31:0] rst_pc  [2];

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata0 <= 32'h100 + (imem_addr0 >> 2);
    always @(posedge clk) imem_rdata1 <= 32'h100 + (imem_addr1 >> 2);

    instr_fetch dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_addr(imem_addr0), .imem_rdata(imem_rdata0),
        .ir(ir0), .pc_plus4(pc_plus4_0), .valid(valid0)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
        .ir(ir1), .pc_plus4(pc_plus4_1), .valid(valid1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_ir [3];
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (valid0 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid0); end
        if (ir0 !== 32'h0) begin errors++; $display("FAIL rst_ir got %h exp 0", ir0); end
        if (pc_plus4_0 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h exp 0", pc_plus4_0); end
        if (imem_addr0 !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr0); end
        if (imem_addr1 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_addr1 got %h exp fffffffc", imem_addr1); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (valid0 !== 1'b0) begin errors++; $display("FAIL first_cycle_valid got %b exp 0", valid0); end
        exp_ir = '{32'h100, 32'h101, 32'h102};
        for (int i = 0; i < 3; i++) begin
            step();
            checks += 3;
            if (valid0 !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b exp 1", i, valid0); end
            if (ir0 !== exp_ir[i]) begin errors++; $display("FAIL seq_ir[%0d] got %h exp %h", i, ir0, exp_ir[i]); end
            if (pc_plus4_0 !== 32'(4 * (i + 1))) begin
                errors++; $display("FAIL seq_pc4[%0d] got %h exp %h", i, pc_plus4_0, 4 * (i + 1));
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) stall = 1'b0;
            checks += 3;
            if (ir0 !== 32'h102) begin errors++; $display("FAIL stall_ir[%0d] got %h exp 102", i, ir0); end
            if (pc_plus4_0 !== 32'd12) begin errors++; $display("FAIL stall_pc4[%0d] got %h exp c", i, pc_plus4_0); end
            if (valid0 !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", i, valid0); end
        end
        step();
        checks += 2;
        if (ir0 !== 32'h103) begin errors++; $display("FAIL stall_next_ir got %h exp 103", ir0); end
        if (pc_plus4_0 !== 32'd16) begin errors++; $display("FAIL stall_next_pc4 got %h exp 10", pc_plus4_0); end
    endtask

    task automatic test_branch(input logic with_jump);
        branch_taken = 1'b1; branch_target = 32'h40;
        jump = with_jump; jump_target = 32'h80;
        step();
        branch_taken = 1'b0; jump = 1'b0;
        checks += 2;
        if (valid0 !== 1'b0) begin errors++; $display("FAIL br_bubble_valid j=%b got %b exp 0", with_jump, valid0); end
        if (ir0 !== 32'h0) begin errors++; $display("FAIL br_bubble_ir j=%b got %h exp 0", with_jump, ir0); end
        step();
        checks += 2;
        if (ir0 !== 32'h110) begin errors++; $display("FAIL br_ir j=%b got %h exp 110", with_jump, ir0); end
        if (pc_plus4_0 !== 32'h44) begin errors++; $display("FAIL br_pc4 j=%b got %h exp 44", with_jump, pc_plus4_0); end
    endtask

    task automatic test_jump_stall();
        stall = 1'b1;
        step();
        jump = 1'b1; jump_target = 32'h83;
        step();
        jump = 1'b0; stall = 1'b0;
        checks += 2;
        if (valid0 !== 1'b0) begin errors++; $display("FAIL js_bubble_valid got %b exp 0", valid0); end
        if (ir0 !== 32'h0) begin errors++; $display("FAIL js_bubble_ir got %h exp 0", ir0); end
        step();
        checks += 2;
        if (ir0 !== 32'h120) begin errors++; $display("FAIL js_ir got %h exp 120", ir0); end
        if (pc_plus4_0 !== 32'h84) begin errors++; $display("FAIL js_pc4 got %h exp 84", pc_plus4_0); end
    endtask

    task automatic test_wrap_and_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        checks += 4;
        if (imem_addr1 !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", imem_addr1); end
        if (pc_plus4_1 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h exp 0", pc_plus4_1); end
        if (valid1 !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b exp 1", valid1); end
        if (ir1 !== 32'h4000_00FF) begin errors++; $display("FAIL wrap_ir got %h exp 400000ff", ir1); end
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (valid0 !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", valid0); end
        if (valid1 !== 1'b0) begin errors++; $display("FAIL midrst_valid1 got %b exp 0", valid1); end
        if (imem_addr0 !== 32'h0) begin errors++; $display("FAIL midrst_addr got %h exp 0", imem_addr0); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        checks += 2;
        if (ir0 !== 32'h100) begin errors++; $display("FAIL midrst_ir got %h exp 100", ir0); end
        if (pc_plus4_0 !== 32'h4) begin errors++; $display("FAIL midrst_pc4 got %h exp 4", pc_plus4_0); end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0; m_addr[k] = '0; m_next[k] = rst_pc[k];
        end
    endtask

    task automatic model_compare(input int cyc);
        logic [31:0] got_ir, got_p4, got_addr, e_ir, e_p4;
        logic        got_v;
        for (int k = 0; k < 2; k++) begin
            got_ir   = (k == 0) ? ir0 : ir1;
            got_p4   = (k == 0) ? pc_plus4_0 : pc_plus4_1;
            got_addr = (k == 0) ? imem_addr0 : imem_addr1;
            got_v    = (k == 0) ? valid0 : valid1;
            e_ir = m_valid[k] ? 32'h100 + (m_addr[k] >> 2) : 32'h0;
            e_p4 = m_valid[k] ? m_addr[k] + 32'd4 : 32'h0;
            checks += 4;
            if (got_v !== m_valid[k]) begin errors++; $display("FAIL rnd_valid dut%0d cyc %0d got %b exp %b", k, cyc, got_v, m_valid[k]); end
            if (got_ir !== e_ir) begin errors++; $display("FAIL rnd_ir dut%0d cyc %0d got %h exp %h", k, cyc, got_ir, e_ir); end
            if (got_p4 !== e_p4) begin errors++; $display("FAIL rnd_pc4 dut%0d cyc %0d got %h exp %h", k, cyc, got_p4, e_p4); end
            if (got_addr !== m_next[k]) begin errors++; $display("FAIL rnd_addr dut%0d cyc %0d got %h exp %h", k, cyc, got_addr, m_next[k]); end
        end
    endtask

    task automatic test_random();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(99) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                model_compare(c);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                continue;
            end
            stall         = ($urandom_range(99) < 30);
            branch_taken  = ($urandom_range(99) < 8);
            jump          = ($urandom_range(99) < 8);
            branch_target = $urandom;
            jump_target   = $urandom;
            step();
            // The visible stream either bubbles on a redirect, freezes on a stall or advances by one word.
            for (int k = 0; k < 2; k++) begin
                if (branch_taken) begin
                    m_valid[k] = 1'b0; m_next[k] = branch_target & ~32'h3;
                end else if (jump) begin
                    m_valid[k] = 1'b0; m_next[k] = jump_target & ~32'h3;
                end else if (!stall) begin
                    m_valid[k] = 1'b1; m_addr[k] = m_next[k]; m_next[k] = m_next[k] + 32'd4;
                end
            end
            model_compare(c);
        end
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    endtask

    initial begin
        rst_pc[0] = 32'h0;
        rst_pc[1] = 32'hFFFF_FFFC;
        test_reset();
        test_stall();
        test_branch(1'b0);
        test_branch(1'b1);
        test_jump_stall();
        test_wrap_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL use one clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 stall  input  1  hazard stall: hold the fetch PC and all outputs.
REQ-006 branch_taken  input  1  redirect to branch_target.
REQ-007 branch_target  input  32  branch destination byte address.
REQ-008 jump  input  1  redirect to jump_target.
REQ-009 jump_target  input  32  jump destination byte address.
REQ-010 imem_addr  output  32  address to synchronous instruction memory; data is returned on the next cycle.
REQ-011 imem_rdata  input  32  instruction word for the address presented on the previous cycle.
REQ-012 ir  output  32  instruction to the IF/ID register.
REQ-013 pc_plus4  output  32  address of ir plus 4.
REQ-014 valid  output  1  ir and pc_plus4 carry a real instruction.

Function
REQ-015 State SHALL be:
- pc: address being fetched this cycle; imem_addr = pc.
- resp_pc and resp_valid: tag of the word on imem_rdata.
- hold_ir, hold_pc and hold_valid: stall skid buffer.
REQ-016 Normal operation (no stall, no redirect) SHALL advance pc by 4 each cycle, with 32-bit wrap (32'hFFFF_FFFC -> 0), and set resp_pc <= pc, resp_valid <= 1.
REQ-017 When hold_valid = 1, outputs SHALL come from the hold registers; otherwise ir = imem_rdata and pc_plus4 = resp_pc + 4, both when resp_valid = 1.
REQ-018 valid SHALL equal hold_valid OR resp_valid.
REQ-019 When valid = 0, ir SHALL be 32'h0 (NOP) and pc_plus4 SHALL be 32'h0.
REQ-020 Stall rising (stall = 1, hold_valid = 0) SHALL capture the current outputs into the hold registers and keep pc unchanged.
REQ-021 While stall = 1, pc, outputs and hold SHALL stay unchanged, and the re-read data on imem_rdata SHALL be discarded.
REQ-022 The cycle stall = 0 with hold_valid = 1 SHALL still present the held instruction, and SHALL then clear hold_valid and advance pc at that edge.
REQ-023 No instruction SHALL be skipped or duplicated across a stall.
REQ-024 On a redirect (branch_taken or jump), pc SHALL be loaded with the target, bits [1:0] forced to 00.
REQ-025 On a redirect, resp_valid and hold_valid SHALL be cleared at that edge, giving exactly one bubble cycle (valid = 0) before the target instruction.
REQ-026 Redirect priority SHALL be: branch_taken over jump over stall.
REQ-027 A redirect during a stall SHALL take effect immediately and discard the held instruction.
REQ-028 Fetch latency SHALL be 1 cycle: an address on imem_addr at edge N appears on ir in cycle N+1.

Reset
REQ-029 rst_n = 0 SHALL asynchronously set pc = RESET_PC, resp_pc = 0, resp_valid = 0, hold_valid = 0, hold_ir = 0 and hold_pc = 0.
REQ-030 During reset, outputs SHALL be ir = 0, pc_plus4 = 0, valid = 0 and imem_addr = RESET_PC.
REQ-031 After reset release, the first clock edge SHALL register the RESET_PC fetch, so valid = 1 from the following cycle.
REQ-032 Reset asserted mid-stream SHALL drop all in-flight and held instructions.

Structure
REQ-033 The shared package SHALL hold the INSTR_W = 32 constant, the NOP = 32'h0 constant and the RESET_PC default.
REQ-034 The skid buffer (hold_ir, hold_pc, hold_valid, with capture and release logic) SHALL be one sub-module, if_hold_buf.
REQ-035 The pc and redirect logic SHALL stay in instr_fetch.

Verification
REQ-036 Reset release, with the memory model returning word = 0x100 + addr/4:
- first cycle after release: valid = 0;
- then ir = 0x100, 0x101, 0x102;
- with pc_plus4 = 4, 8, 12.
REQ-037 Stall for 3 cycles while ir = 0x102:
- ir = 0x102 and pc_plus4 = 12 stable for 4 cycles;
- then 0x103 follows, with no gap or repeat.
REQ-038 branch_taken with branch_target = 0x40:
- next cycle: valid = 0, ir = 0;
- then ir = 0x110 with pc_plus4 = 0x44.
REQ-039 branch_taken (target 0x40) and jump (target 0x80) in the same cycle -> after the bubble, ir = 0x110 (branch wins).
REQ-040 jump to 0x83 while stalled:
- hold discarded, one bubble;
- then ir = 0x120 and pc_plus4 = 0x84.
REQ-041 RESET_PC = 32'hFFFF_FFFC:
- imem_addr wraps to 0 on the next cycle;
- pc_plus4 = 0 for the first instruction.
- Separately, rst_n pulsed low mid-stream -> valid = 0 immediately, then the fetch restarts at RESET_PC.
